// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Operands are captured on an accepted start; done pulses one cycle after the last bit.
module serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CntW-1:0]  r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

    state_e           w_state_next;
    logic [WIDTH-1:0] w_a_sh_next;
    logic [WIDTH-1:0] w_b_sh_next;
    logic [WIDTH-1:0] w_s_sh_next;
    logic             w_carry_next;
    logic [CntW-1:0]  w_cnt_next;
    logic             w_done_next;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_cout_next;
    logic             w_overflow_next;

    // The single full-adder cell working on the current LSBs.
    logic w_s;
    logic w_maj;

    assign w_s   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_maj = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    always_comb begin
        w_state_next    = r_state;
        w_a_sh_next     = r_a_sh;
        w_b_sh_next     = r_b_sh;
        w_s_sh_next     = r_s_sh;
        w_carry_next    = r_carry;
        w_cnt_next      = r_cnt;
        w_done_next     = 1'b0;
        w_sum_next      = r_sum;
        w_cout_next     = r_cout;
        w_overflow_next = r_overflow;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_a_sh_next  = i_a;
                    w_b_sh_next  = i_b;
                    w_carry_next = i_cin;
                    w_cnt_next   = '0;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_a_sh_next  = {1'b0, r_a_sh[WIDTH-1:1]};
                w_b_sh_next  = {1'b0, r_b_sh[WIDTH-1:1]};
                w_s_sh_next  = {w_s, r_s_sh[WIDTH-1:1]};
                w_carry_next = w_maj;
                w_cnt_next   = r_cnt + 1'b1;
                if (r_cnt == LastCnt) begin
                    // r_carry here is the carry into the MSB, w_maj the carry out of it.
                    w_sum_next      = {w_s, r_s_sh[WIDTH-1:1]};
                    w_cout_next     = w_maj;
                    w_overflow_next = r_carry ^ w_maj;
                    w_done_next     = 1'b1;
                    w_state_next    = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_s_sh     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_a_sh     <= w_a_sh_next;
            r_b_sh     <= w_b_sh_next;
            r_s_sh     <= w_s_sh_next;
            r_carry    <= w_carry_next;
            r_cnt      <= w_cnt_next;
            r_done     <= w_done_next;
            r_sum      <= w_sum_next;
            r_cout     <= w_cout_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_busy     = (r_state == StRun);
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, random, handshake, abort,
// and an exhaustive sweep of a 4-bit instance against an arithmetic reference.
module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .i_cin      (cin),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_cout     (cout),
        .o_overflow (ovf)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start4),
        .i_a        (a4),
        .i_b        (b4),
        .i_cin      (cin4),
        .o_busy     (busy4),
        .o_done     (done4),
        .o_sum      (sum4),
        .o_cout     (cout4),
        .o_overflow (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow when operands share a sign
    // and the truncated result does not.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic c);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] s;
        logic        co;
        logic        sx, sy, ss;
        full = {1'b0, x} + {1'b0, y} + {64'd0, c};
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        s    = full[63:0] & mask;
        co   = full[w];
        sx   = x[w-1];
        sy   = y[w-1];
        ss   = s[w-1];
        return {(sx == sy) && (ss != sx), co, s};
    endfunction

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output int lat);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                        output int lat);
        start4 = 1'b1;
        a4     = av;
        b4     = bv;
        cin4   = cv;
        @(negedge clk);
        start4 = 1'b0;
        lat    = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];

    initial begin
        int          lat;
        logic [65:0] r;
        res_t        last;
        res_t        got;
        logic [15:0] ra, rb;
        logic        rc;
        int          saw_done;

        vecs[0] = '{16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset, including a start pulse that reset must override.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run16(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_sum_held", i), 64'(sum), 64'(vecs[i].sum));
        end
        last = '{vecs[5].sum, vecs[5].cout, vecs[5].ovf};

        // Random operands; back-to-back so start also lands in the done cycle.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            r  = ref_add(16, 64'(ra), 64'(rb), rc);
            run16(ra, rb, rc, lat);
            check("rand_latency", 64'(lat), 64'd16);
            check("rand_sum", 64'(sum), 64'(r[15:0]));
            check("rand_cout", 64'(cout), 64'(r[64]));
            check("rand_ovf", 64'(ovf), 64'(r[65]));
            last = '{r[15:0], r[64], r[65]};
        end
        @(negedge clk);

        // start held high, operands changing every cycle.
        exp_q.delete();
        for (int n = 0; n < 68; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            start = 1'b1; a = ra; b = rb; cin = rc;
            if (n % 17 == 0) begin
                r = ref_add(16, 64'(ra), 64'(rb), rc);
                exp_q.push_back('{r[15:0], r[64], r[65]});
            end
            @(negedge clk);
            check("hs_done", 64'(done), 64'(n % 17 == 16));
            check("hs_busy", 64'(busy), 64'(n % 17 != 16));
            if (n % 17 == 16 && exp_q.size() > 0) begin
                last = exp_q.pop_front();
            end
            got = '{sum, cout, ovf};
            check("hs_result", 64'({got.sum, got.cout, got.ovf}),
                  64'({last.sum, last.cout, last.ovf}));
        end
        start = 1'b0;
        @(negedge clk);

        // Abort during bit 7.
        ra = 16'h4321; rb = 16'h1F1F;
        start = 1'b1; a = ra; b = rb; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done++;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        r = ref_add(16, 64'(ra), 64'(rb), 1'b1);
        run16(ra, rb, 1'b1, lat);
        check("after_abort_latency", 64'(lat), 64'd16);
        check("after_abort_sum", 64'({cout, sum}), 64'({r[64], r[15:0]}));
        check("after_abort_ovf", 64'(ovf), 64'(r[65]));
        @(negedge clk);

        // Exhaustive 4-bit sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            r = ref_add(4, 64'(v[8:5]), 64'(v[4:1]), v[0]);
            run4(v[8:5], v[4:1], v[0], lat);
            check("w4_latency", 64'(lat), 64'd4);
            check("w4_cout_sum", 64'({cout4, sum4}), 64'({r[64], r[3:0]}));
            check("w4_ovf", 64'(ovf4), 64'(r[65]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
